// File: rtl/oam_dma_pkg.sv
// Shared types and constants for the OAM DMA controller.
// Optional build macro: OAM_DMA_ALIGN_EN (adds the parity-driven ALIGN cycle).
package oam_dma_pkg;

    // FSM states of the DMA engine
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HALT  = 3'd1,
        ALIGN = 3'd2,
        READ  = 3'd3,
        WRITE = 3'd4
    } state_e;

    // Default CPU trigger register and fixed OAM data port
    localparam logic [15:0] DMA_REG_ADDR_DEF = 16'h4014;
    localparam logic [15:0] DEST_ADDR_DEF    = 16'h2004;

    // A CPU write cycle to the DMA register starts a transfer
    function automatic logic is_dma_trigger(input logic [15:0] addr,
                                            input logic        rw,
                                            input logic [15:0] reg_addr);
        return (rw == 1'b0) && (addr == reg_addr);
    endfunction

endpackage

// File: rtl/oam_dma_if.sv
// CPU-side request and shared-bus signals of the OAM DMA controller.
// Optional build macro: OAM_DMA_ALIGN_EN (no effect on this interface).
interface oam_dma_if;
    logic [15:0] cpu_addr;
    logic        cpu_rw;
    logic [7:0]  cpu_data_out;
    logic        cpu_rdy;
    logic [15:0] bus_addr;
    logic        bus_rw;
    logic [7:0]  bus_data_out;
    logic [7:0]  bus_data_in;
    logic        busy;

    // CPU/memory side (drives requests and read data)
    modport master (
        output cpu_addr, cpu_rw, cpu_data_out, bus_data_in,
        input  cpu_rdy, bus_addr, bus_rw, bus_data_out, busy
    );

    // DMA controller side
    modport slave (
        input  cpu_addr, cpu_rw, cpu_data_out, bus_data_in,
        output cpu_rdy, bus_addr, bus_rw, bus_data_out, busy
    );
endinterface

// File: rtl/oam_dma_ctrl.sv
// OAM DMA controller: a CPU write of a page number to DMA_REG_ADDR halts the
// CPU and copies 256 bytes from {page, 00..FF} to DEST_ADDR, one read and one
// write per byte. In IDLE the CPU bus passes straight through to the shared bus.
// Optional build macro: OAM_DMA_ALIGN_EN (when defined, a halt that starts on an
// odd parity cycle inserts one extra ALIGN cycle before the first read).
module oam_dma_ctrl
    import oam_dma_pkg::*;
#(
    parameter logic [15:0] DMA_REG_ADDR = DMA_REG_ADDR_DEF,
    parameter logic [15:0] DEST_ADDR    = DEST_ADDR_DEF
) (
    input  logic         clock,
    input  logic         reset,
    oam_dma_if.slave     dma
);

    state_e     state_q, state_d;
    logic [7:0] page_q,  page_d;
    logic [7:0] idx_q,   idx_d;
    logic [7:0] data_q,  data_d;

`ifdef OAM_DMA_ALIGN_EN
    logic parity_q, parity_d;

    // Free-running cycle parity, toggles every clock in every state
    always_comb begin
        parity_d = ~parity_q;
    end

    // Parity register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end
`endif

    // State, page, index and data registers; reset aborts any transfer
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            page_q  <= 8'h00;
            idx_q   <= 8'h00;
            data_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            page_q  <= page_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
        end
    end

    // Next-state logic and the inline bus mux (passthrough unless overridden)
    always_comb begin
        state_d          = state_q;
        page_d           = page_q;
        idx_d            = idx_q;
        data_d           = data_q;
        dma.bus_addr     = dma.cpu_addr;
        dma.bus_rw       = dma.cpu_rw;
        dma.bus_data_out = dma.cpu_data_out;
        dma.cpu_rdy      = 1'b0;

        case (state_q)
            IDLE: begin
                dma.cpu_rdy = 1'b1;
                if (is_dma_trigger(dma.cpu_addr, dma.cpu_rw, DMA_REG_ADDR)) begin
                    page_d  = dma.cpu_data_out;
                    idx_d   = 8'h00;
                    state_d = HALT;
                end else begin
                    state_d = IDLE;
                end
            end
            HALT: begin
                // Dummy read at the CPU's address while the CPU halts
                dma.bus_rw = 1'b1;
`ifdef OAM_DMA_ALIGN_EN
                state_d = parity_q ? ALIGN : READ;
`else
                state_d = READ;
`endif
            end
            ALIGN: begin
                dma.bus_rw = 1'b1;
                state_d    = READ;
            end
            READ: begin
                dma.bus_addr = {page_q, idx_q};
                dma.bus_rw   = 1'b1;
                data_d       = dma.bus_data_in;
                state_d      = WRITE;
            end
            WRITE: begin
                dma.bus_addr     = DEST_ADDR;
                dma.bus_rw       = 1'b0;
                dma.bus_data_out = data_q;
                idx_d            = idx_q + 8'd1;
                state_d          = (idx_q == 8'hFF) ? IDLE : READ;
            end
            default: begin
                dma.cpu_rdy = 1'b1;
                state_d     = IDLE;
            end
        endcase
    end

    // Busy whenever a transfer is in progress
    always_comb begin
        dma.busy = (state_q != IDLE);
    end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Self-checking bench for oam_dma_ctrl: table-driven IDLE passthrough vectors
// plus hand-written full-transfer, parity, reset-abort and page-FF sequences.
// Honours OAM_DMA_ALIGN_EN for the expected stall length.
module tb_oam_dma_ctrl;
    import oam_dma_pkg::*;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    logic tb_par;

    oam_dma_if dif ();

    oam_dma_ctrl #(
        .DMA_REG_ADDR(16'h4014),
        .DEST_ADDR   (16'h2004)
    ) dut (
        .clock(clk),
        .reset(rst),
        .dma  (dif.slave)
    );

    // Memory model: a fixed function of the address
    function automatic logic [7:0] mem(input logic [15:0] a);
        return {a[3:0], a[7:4]} ^ a[15:8] ^ 8'h5C;
    endfunction

    assign dif.bus_data_in = mem(dif.bus_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference parity: value of the DUT's cycle parity during the current cycle
    always @(posedge clk or posedge rst) begin
        if (rst) tb_par <= 1'b0;
        else     tb_par <= ~tb_par;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [15:0] a, input logic rw, input logic [7:0] d);
        dif.cpu_addr     = a;
        dif.cpu_rw       = rw;
        dif.cpu_data_out = d;
    endtask

    // Trigger a transfer of 'page' in a cycle whose parity is want_par and
    // follow it cycle by cycle until cpu_rdy returns.
    task automatic run_dma(input logic [7:0] page, input logic want_par);
        int halt_n;
        int exp_stall;
        int stall;
        int errs;
        int k;
        int i;
        @(negedge clk);
        if (tb_par != want_par) @(negedge clk);
        drive(16'h4014, 1'b0, page);
        #1;
        check("trig_passthru_addr", {16'h0, dif.bus_addr}, 32'h4014);
        check("trig_passthru_rw", {31'h0, dif.bus_rw}, 32'h0);
        check("trig_passthru_data", {24'h0, dif.bus_data_out}, {24'h0, page});
`ifdef OAM_DMA_ALIGN_EN
        halt_n = (want_par == 1'b0) ? 2 : 1;
`else
        halt_n = 1;
`endif
        exp_stall = 512 + halt_n;
        stall = 0;
        errs  = 0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            if (c == 10) drive(16'h4014, 1'b0, 8'h07);
            else         drive(16'h8000, 1'b1, 8'h00);
            #1;
            if (dif.cpu_rdy === 1'b1) break;
            stall++;
            if (dif.busy !== 1'b1) errs++;
            if (c < halt_n) begin
                if (dif.bus_addr !== 16'h8000 || dif.bus_rw !== 1'b1) errs++;
            end else begin
                k = c - halt_n;
                i = k / 2;
                if (k >= 512) begin
                    errs++;
                end else if (k % 2 == 0) begin
                    if (dif.bus_addr !== {page, i[7:0]} || dif.bus_rw !== 1'b1) errs++;
                end else begin
                    if (dif.bus_addr !== 16'h2004 || dif.bus_rw !== 1'b0 ||
                        dif.bus_data_out !== mem({page, i[7:0]})) errs++;
                end
            end
        end
        check("xfer_seq_errs", errs, 0);
        check("stall_len", stall, exp_stall);
        check("end_busy", {31'h0, dif.busy}, 32'h0);
        check("end_passthru", {16'h0, dif.bus_addr}, {16'h0, dif.cpu_addr});
    endtask

    typedef struct {
        logic [15:0] addr;
        logic        rw;
        logic [7:0]  data;
        logic [15:0] exp_addr;
        logic        exp_rw;
        logic [7:0]  exp_data;
    } vec_t;

    vec_t vecs [5];
    bit   found;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        vecs[0] = '{16'h4000, 1'b1, 8'h00, 16'h4000, 1'b1, 8'h00};
        vecs[1] = '{16'h4002, 1'b0, 8'h5A, 16'h4002, 1'b0, 8'h5A};
        vecs[2] = '{16'h4014, 1'b1, 8'h33, 16'h4014, 1'b1, 8'h33};
        vecs[3] = '{16'h4015, 1'b0, 8'h02, 16'h4015, 1'b0, 8'h02};
        vecs[4] = '{16'hFFFF, 1'b0, 8'hC3, 16'hFFFF, 1'b0, 8'hC3};

        rst = 1'b1;
        drive(16'h1234, 1'b0, 8'hA7);
        repeat (3) @(negedge clk);
        #1;
        check("rst_busy", {31'h0, dif.busy}, 32'h0);
        check("rst_rdy", {31'h0, dif.cpu_rdy}, 32'h1);
        check("rst_passthru_addr", {16'h0, dif.bus_addr}, 32'h1234);
        check("rst_passthru_data", {24'h0, dif.bus_data_out}, 32'hA7);
        @(negedge clk);
        rst = 1'b0;

        // IDLE passthrough vectors; none of them is a trigger
        for (int v = 0; v < 5; v++) begin
            @(negedge clk);
            drive(vecs[v].addr, vecs[v].rw, vecs[v].data);
            #1;
            check("idle_addr", {16'h0, dif.bus_addr}, {16'h0, vecs[v].exp_addr});
            check("idle_rw", {31'h0, dif.bus_rw}, {31'h0, vecs[v].exp_rw});
            check("idle_data", {24'h0, dif.bus_data_out}, {24'h0, vecs[v].exp_data});
            check("idle_busy", {31'h0, dif.busy}, 32'h0);
            check("idle_rdy", {31'h0, dif.cpu_rdy}, 32'h1);
        end
        @(negedge clk);
        drive(16'h8000, 1'b1, 8'h00);
        #1;
        check("no_false_trigger", {31'h0, dif.busy}, 32'h0);

        // Parity 0 at HALT, then parity 1 at HALT
        run_dma(8'h02, 1'b1);
        run_dma(8'h02, 1'b0);

        // Abort at byte 0x40 with reset
        @(negedge clk);
        drive(16'h4014, 1'b0, 8'h01);
        found = 1'b0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            drive(16'h8000, 1'b1, 8'h00);
            #1;
            if (dif.bus_addr === 16'h0140) begin
                found = 1'b1;
                break;
            end
        end
        check("abort_reached_0x40", {31'h0, found}, 32'h1);
        rst = 1'b1;
        #1;
        check("abort_busy", {31'h0, dif.busy}, 32'h0);
        check("abort_rdy", {31'h0, dif.cpu_rdy}, 32'h1);
        check("abort_passthru", {16'h0, dif.bus_addr}, 32'h8000);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        check("abort_no_resume", {31'h0, dif.busy}, 32'h0);
        run_dma(8'h03, 1'b1);

        // Last page: reads end at FFFF with no wrap
        run_dma(8'hFF, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/oam_dma_ctrl.md
OAM_DMA_CTRL -- requirements
Module: oam_dma_ctrl

Interface
REQ-001 The block SHALL have parameter DMA_REG_ADDR, default 16'h4014; it is the CPU write address that triggers DMA.
REQ-002 The block SHALL have parameter DEST_ADDR, default 16'h2004; it is the fixed write address for every transferred byte.
REQ-003 The block SHALL have port clock, input, width 1; it is the single CPU-rate clock, and all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, width 1; it is the asynchronous, active-high reset.
REQ-005 The block SHALL have ports cpu_addr (input, width 16), cpu_rw (input, width 1, 1=read) and cpu_data_out (input, width 8); these carry the CPU bus request.
REQ-006 The block SHALL have port cpu_rdy, output, width 1; it is the CPU halt, where 0 stalls the CPU.
REQ-007 The block SHALL have ports bus_addr (output, width 16), bus_rw (output, width 1) and bus_data_out (output, width 8); these drive the shared memory/peripheral bus.
REQ-008 The block SHALL have port bus_data_in, input, width 8; it is the read data from the bus and is valid at the end of the cycle that presents the address.
REQ-009 The block SHALL have port busy, output, width 1; it is 1 whenever the state is not IDLE.

Function
REQ-010 The block SHALL use FSM states IDLE, HALT, ALIGN, READ and WRITE.
REQ-011 In IDLE, bus_addr, bus_rw and bus_data_out SHALL equal cpu_addr, cpu_rw and cpu_data_out combinationally, and cpu_rdy SHALL be 1.
REQ-012 In IDLE, a cycle with cpu_rw=0 and cpu_addr=DMA_REG_ADDR SHALL pass the write through to the bus, latch page=cpu_data_out, clear idx to 8'h00, and enter HALT on the next edge.
REQ-013 In HALT, cpu_rdy SHALL be 0, bus_rw SHALL be 1 and bus_addr SHALL be cpu_addr (dummy read); the next state SHALL be ALIGN when the parity bit is 1, else READ.
REQ-014 In ALIGN, cpu_rdy SHALL be 0, bus_rw SHALL be 1 and bus_addr SHALL be cpu_addr; the next state SHALL be READ.
REQ-015 In READ, cpu_rdy SHALL be 0, bus_addr SHALL be {page, idx} and bus_rw SHALL be 1; bus_data_in SHALL be latched into the data register at the edge, and the next state SHALL be WRITE.
REQ-016 In WRITE, cpu_rdy SHALL be 0, bus_addr SHALL be DEST_ADDR, bus_rw SHALL be 0 and bus_data_out SHALL be the data register; idx SHALL increment modulo 256.
REQ-017 From WRITE, the FSM SHALL return to READ when idx was not 8'hFF, else go to IDLE.
REQ-018 The parity bit SHALL toggle every clock regardless of state.
REQ-019 CPU writes to DMA_REG_ADDR while busy=1 SHALL be ignored.
REQ-020 The stall length SHALL be 513 cycles (parity 0 at HALT) or 514 cycles (parity 1 at HALT), after which cpu_rdy=1 in IDLE.
REQ-021 Page 8'hFF SHALL read 16'hFF00..16'hFFFF with no wrap into page 0.

Reset
REQ-022 Asserting reset SHALL immediately set state=IDLE, page=0, idx=0, data register=0, parity=0, cpu_rdy=1 and busy=0, including mid-transfer; an aborted transfer SHALL NOT resume.
REQ-023 While reset is asserted, the bus outputs SHALL equal the IDLE passthrough.

Configuration
REQ-024 With OAM_DMA_ALIGN_EN defined, the ALIGN state and the parity bit SHALL exist per REQ-013 and REQ-018.
REQ-025 Without OAM_DMA_ALIGN_EN, HALT SHALL always go to READ and the stall SHALL be exactly 513 cycles.

Structure
REQ-026 Package oam_dma_pkg SHALL hold the FSM state typedef and the default address constants 16'h4014 and 16'h2004.
REQ-027 The block SHALL be a single module with no sub-module; the bus mux SHALL be inline combinational logic.

Verification
REQ-028 With parity 0, writing 8'h02 to 16'h4014 SHALL produce reads at 16'h0200..16'h02FF alternating with writes to 16'h2004 carrying the read bytes in order, and cpu_rdy low for 513 cycles.
REQ-029 The same trigger issued one cycle later (parity 1) SHALL keep cpu_rdy low for 514 cycles, or 513 cycles when OAM_DMA_ALIGN_EN is undefined.
REQ-030 Asserting reset at transfer byte 8'h40 SHALL give busy=0 and cpu_rdy=1 immediately; a following write of 8'h03 SHALL start from 16'h0300.
REQ-031 A page-8'hFF transfer SHALL end its reads at 16'hFFFF, and the FSM SHALL be IDLE with cpu_rdy=1 on the cycle after the final 16'h2004 write.
REQ-032 In IDLE, a CPU read of 16'h4000 and a CPU write of 8'h5A to 16'h4002 SHALL appear unchanged on the bus with busy=0.
